// File: rtl/nvdla_glb_done_intr_ctrl.sv
// Done-interrupt collector for GLB.
// Sticky per-group done status with mask and a registered core interrupt level.
// Every done event is also queued in a pending vector and streamed out one at a
// time through a single-entry valid/ready register fed by a round-robin arbiter.
module nvdla_glb_done_intr_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int SRC_W   = 3
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [2*NUM_SRC-1:0]   done_src_pd,
  input  logic                   status_clr_en,
  input  logic [2*NUM_SRC-1:0]   status_clr_data,
  input  logic                   mask_wr_en,
  input  logic [2*NUM_SRC-1:0]   mask_wr_data,
  input  logic                   swset_en,
  input  logic [2*NUM_SRC-1:0]   swset_data,
  output logic [2*NUM_SRC-1:0]   status_rd,
  output logic [2*NUM_SRC-1:0]   mask_rd,
  output logic                   core_intr,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [SRC_W-1:0]       evt_src,
  output logic                   evt_grp,
  output logic                   evt_ovf
);

  localparam int NB    = 2 * NUM_SRC;
  localparam int IDX_W = $clog2(NB);
  localparam int CW    = IDX_W + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} evt_state_e;

  logic [NB-1:0]    set_vec;
  logic [NB-1:0]    clr_vec;
  logic [NB-1:0]    status_q, status_d;
  logic [NB-1:0]    mask_q;
  logic             core_intr_q;
  logic [NB-1:0]    pending_q, pending_d;
  logic             evt_ovf_q, evt_ovf_d;
  evt_state_e       state_q;
  logic             evt_valid_q;
  logic [SRC_W-1:0] evt_src_q;
  logic             evt_grp_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [CW-1:0]    cand;
  logic             grant;
  logic [NB-1:0]    grant_vec;

  // Combine hardware done pulses with the software set path; build the W1C clear vector.
  always_comb begin
    set_vec  = done_src_pd | (swset_en ? swset_data : '0);
    clr_vec  = status_clr_en ? status_clr_data : '0;
    status_d = set_vec | (status_q & ~clr_vec);
  end

  // Round-robin pick: first pending bit at or after rr_ptr, wrapping at NB.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NB; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NB)) cand = cand - CW'(NB);
      if (!pick_found && pending_q[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grant whenever the output slot is free or being drained this cycle.
  always_comb begin
    grant     = pick_found && ((state_q == IDLE) || evt_ready);
    grant_vec = grant ? (NB'(1) << pick_idx) : '0;
    rr_nxt    = (pick_idx == IDX_W'(NB - 1)) ? '0 : pick_idx + 1'b1;
    // A re-set on a bit granted this same cycle is a fresh event, not a loss.
    pending_d = (pending_q & ~grant_vec) | set_vec;
    evt_ovf_d = evt_ovf_q;
    if (|(set_vec & pending_q & ~grant_vec)) evt_ovf_d = 1'b1;
    else if (swset_en && (swset_data == '0)) evt_ovf_d = 1'b0;
  end

  // Status, mask, interrupt level, pending vector and overflow flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      status_q    <= '0;
      mask_q      <= '1;
      core_intr_q <= 1'b0;
      pending_q   <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      status_q    <= status_d;
      if (mask_wr_en) mask_q <= mask_wr_data;
      core_intr_q <= |(status_q & ~mask_q);
      pending_q   <= pending_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  // Single-entry event output FSM with registered outputs.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_src_q   <= '0;
      evt_grp_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q     <= HOLD;
            evt_valid_q <= 1'b1;
            evt_src_q   <= SRC_W'(pick_idx >> 1);
            evt_grp_q   <= pick_idx[0];
            rr_ptr_q    <= rr_nxt;
          end
        end
        HOLD: begin
          if (evt_ready) begin
            if (grant) begin
              evt_src_q <= SRC_W'(pick_idx >> 1);
              evt_grp_q <= pick_idx[0];
              rr_ptr_q  <= rr_nxt;
            end else begin
              state_q     <= IDLE;
              evt_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign status_rd = status_q;
  assign mask_rd   = mask_q;
  assign core_intr = core_intr_q;
  assign evt_valid = evt_valid_q;
  assign evt_src   = evt_src_q;
  assign evt_grp   = evt_grp_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_nvdla_glb_done_intr_ctrl.sv
// Directed bench for the GLB done-interrupt collector.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_nvdla_glb_done_intr_ctrl;

  localparam int NUM_SRC = 6;
  localparam int SRC_W   = 3;
  localparam int NB      = 2 * NUM_SRC;

  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic [NB-1:0]    done_src_pd;
  logic             status_clr_en;
  logic [NB-1:0]    status_clr_data;
  logic             mask_wr_en;
  logic [NB-1:0]    mask_wr_data;
  logic             swset_en;
  logic [NB-1:0]    swset_data;
  logic [NB-1:0]    status_rd;
  logic [NB-1:0]    mask_rd;
  logic             core_intr;
  logic             evt_valid;
  logic             evt_ready;
  logic [SRC_W-1:0] evt_src;
  logic             evt_grp;
  logic             evt_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  nvdla_glb_done_intr_ctrl #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .done_src_pd     (done_src_pd),
    .status_clr_en   (status_clr_en),
    .status_clr_data (status_clr_data),
    .mask_wr_en      (mask_wr_en),
    .mask_wr_data    (mask_wr_data),
    .swset_en        (swset_en),
    .swset_data      (swset_data),
    .status_rd       (status_rd),
    .mask_rd         (mask_rd),
    .core_intr       (core_intr),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_src         (evt_src),
    .evt_grp         (evt_grp),
    .evt_ovf         (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    done_src_pd     = '0;
    status_clr_en   = 1'b0;
    status_clr_data = '0;
    mask_wr_en      = 1'b0;
    mask_wr_data    = '0;
    swset_en        = 1'b0;
    swset_data      = '0;
    evt_ready       = 1'b0;
    rstn            = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_status", 32'(status_rd), 32'h000);
    chk("rst_mask",   32'(mask_rd),   32'hFFF);
    chk("rst_intr",   32'(core_intr), 32'h0);
    chk("rst_valid",  32'(evt_valid), 32'h0);
    chk("rst_src",    32'(evt_src),   32'h0);
    chk("rst_grp",    32'(evt_grp),   32'h0);
    chk("rst_ovf",    32'(evt_ovf),   32'h0);

    // T1: unmask, single done on bit2 (source 1, group 0)
    mask_wr_en = 1'b1; mask_wr_data = 12'h000;
    cyc();
    mask_wr_en = 1'b0;
    chk("t1_mask", 32'(mask_rd), 32'h000);
    done_src_pd = 12'h004;
    cyc();
    done_src_pd = '0;
    chk("t1_status", 32'(status_rd), 32'h004);
    chk("t1_intr_t1", 32'(core_intr), 32'h0);
    cyc();
    chk("t1_intr_t2", 32'(core_intr), 32'h1);
    chk("t1_valid",   32'(evt_valid), 32'h1);
    chk("t1_src",     32'(evt_src),   32'h1);
    chk("t1_grp",     32'(evt_grp),   32'h0);
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("t1_drained", 32'(evt_valid), 32'h0);

    // T2: masked done, then unmask
    mask_wr_en = 1'b1; mask_wr_data = 12'hFFF;
    status_clr_en = 1'b1; status_clr_data = 12'hFFF;
    cyc();
    mask_wr_en = 1'b0; status_clr_en = 1'b0;
    chk("t2_cleared", 32'(status_rd), 32'h000);
    cyc();
    chk("t2_intr_off", 32'(core_intr), 32'h0);
    done_src_pd = 12'h001;
    cyc();
    done_src_pd = '0;
    chk("t2_status", 32'(status_rd), 32'h001);
    cyc();
    chk("t2_masked_intr", 32'(core_intr), 32'h0);
    mask_wr_en = 1'b1; mask_wr_data = 12'h000; evt_ready = 1'b1;
    cyc();
    mask_wr_en = 1'b0;
    chk("t2_intr_wait", 32'(core_intr), 32'h0);
    cyc();
    chk("t2_intr_on", 32'(core_intr), 32'h1);
    chk("t2_status_kept", 32'(status_rd), 32'h001);

    // T3: clear and set of bit0 in the same cycle, set wins
    status_clr_en = 1'b1; status_clr_data = 12'h001;
    cyc();
    chk("t3_clr", 32'(status_rd), 32'h000);
    done_src_pd = 12'h001;
    cyc();
    done_src_pd = '0; status_clr_en = 1'b0;
    chk("t3_set_wins", 32'(status_rd), 32'h001);

    // T4: all twelve bits at once, drained back to back in index order
    do_reset();
    evt_ready   = 1'b1;
    done_src_pd = 12'hFFF;
    cyc();
    done_src_pd = '0;
    chk("t4_status", 32'(status_rd), 32'hFFF);
    cyc();
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("t4_valid%0d", i), 32'(evt_valid), 32'h1);
      chk($sformatf("t4_src%0d", i),   32'(evt_src),   32'(i >> 1));
      chk($sformatf("t4_grp%0d", i),   32'(evt_grp),   32'(i & 1));
      cyc();
    end
    chk("t4_idle", 32'(evt_valid), 32'h0);
    chk("t4_ovf",  32'(evt_ovf),   32'h0);

    // T5: stalled consumer, repeated done on bit3 (source 1, group 1)
    do_reset();
    mask_wr_en = 1'b1; mask_wr_data = 12'h000;
    cyc();
    mask_wr_en = 1'b0;
    done_src_pd = 12'h008;
    cyc();
    done_src_pd = '0;
    cyc();
    chk("t5_valid", 32'(evt_valid), 32'h1);
    chk("t5_src",   32'(evt_src),   32'h1);
    chk("t5_grp",   32'(evt_grp),   32'h1);
    // second pulse refills pending behind the held event
    done_src_pd = 12'h008;
    cyc();
    done_src_pd = '0;
    cyc();
    // third pulse lands on a bit that is still pending and not grantable
    done_src_pd = 12'h008;
    cyc();
    done_src_pd = '0;
    chk("t5_ovf",       32'(evt_ovf),   32'h1);
    chk("t5_hold_vld",  32'(evt_valid), 32'h1);
    chk("t5_hold_src",  32'(evt_src),   32'h1);
    chk("t5_hold_grp",  32'(evt_grp),   32'h1);
    chk("t5_intr",      32'(core_intr), 32'h1);
    swset_en = 1'b1; swset_data = 12'h000;
    cyc();
    swset_en = 1'b0;
    chk("t5_ovf_clr", 32'(evt_ovf), 32'h0);
    done_src_pd = 12'h008;
    cyc();
    done_src_pd = '0;
    chk("t5_ovf_again", 32'(evt_ovf), 32'h1);

    // T6: asynchronous reset while an event is held and another pending
    #2 rstn = 1'b0;
    #1;
    chk("t6_status", 32'(status_rd), 32'h000);
    chk("t6_mask",   32'(mask_rd),   32'hFFF);
    chk("t6_intr",   32'(core_intr), 32'h0);
    chk("t6_valid",  32'(evt_valid), 32'h0);
    chk("t6_src",    32'(evt_src),   32'h0);
    chk("t6_grp",    32'(evt_grp),   32'h0);
    chk("t6_ovf",    32'(evt_ovf),   32'h0);
    @(negedge clk);
    rstn = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t6_no_replay%0d", i), 32'(evt_valid), 32'h0);
    end

    // Software set on bit11 (source 5, group 1)
    swset_en = 1'b1; swset_data = 12'h800;
    cyc();
    swset_en = 1'b0; swset_data = '0;
    chk("sw_status", 32'(status_rd), 32'h800);
    cyc();
    chk("sw_valid", 32'(evt_valid), 32'h1);
    chk("sw_src",   32'(evt_src),   32'h5);
    chk("sw_grp",   32'(evt_grp),   32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
